// File: rtl/sevseg_pkg.sv
// Seven-segment code table and capture FSM state type.
// Shared by the display scanner (encoder) and sevseg_capture (decoder).
package sevseg_pkg;

    // All seven segments off (active-low {G..A}).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {G,F,E,D,C,B,A} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/sevseg_capture_if.sv
// Display bus between a four-digit scanner and its reader.
// master: drives ANODES/CATHODES, reads the decoded frame; slave: the capture block.
interface sevseg_capture_if;
    logic [3:0]  ANODES;
    logic [7:0]  CATHODES;
    logic [15:0] DIGITS;
    logic [3:0]  DP;
    logic [3:0]  BLANK;
    logic [3:0]  ERR;
    logic        FRAME_STB;
    logic        VALID;
    logic        DISP_OFF;

    modport master (
        output ANODES, CATHODES,
        input  DIGITS, DP, BLANK, ERR,
        input  FRAME_STB, VALID, DISP_OFF
    );

    modport slave (
        input  ANODES, CATHODES,
        output DIGITS, DP, BLANK, ERR,
        output FRAME_STB, VALID, DISP_OFF
    );
endinterface

// File: rtl/seg_decode.sv
// Combinational segment decoder: 7-bit active-low {G..A} -> {hit, blank, nibble}.
// seg in; hit = pattern in table, blank = all off, nib = table index on hit.
module seg_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nib
);

    always_comb begin
        hit   = 1'b0;
        blank = (seg == SEG_BLANK);
        nib   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                hit = 1'b1;
                nib = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevseg_capture.sv
// Reads a multiplexed 4-digit seven-segment drive back into nibbles/DP/flags.
// Ports: CLK, RST_N (async low); bus (slave): ANODES/CATHODES in, frame outputs.
module sevseg_capture
    import sevseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input logic             CLK,
    input logic             RST_N,
    sevseg_capture_if.slave bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]    an_s1, an_s2, ref_an;
    logic [7:0]    ca_s1, ca_s2, ref_ca;
    cap_state_t    state, state_n;
    logic [SW-1:0] stab_cnt, cnt_n;
    logic [TW-1:0] to_cnt, to_n;
    logic [3:0]    seen;
    logic [15:0]   digits;
    logic [3:0]    dp, blank, err;
    logic          frame_stb, valid, disp_off;

    logic          legal, same, ld, cap;
    logic          seen_full, to_hit;
    logic [1:0]    idx;
    logic [3:0]    cap_mask;
    logic          d_hit, d_blank;
    logic [3:0]    d_nib;

    // Two-flop synchronizers; reset to "nothing driven".
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_s1 <= 4'hF;
            an_s2 <= 4'hF;
            ca_s1 <= 8'hFF;
            ca_s2 <= 8'hFF;
        end else begin
            an_s1 <= bus.ANODES;
            an_s2 <= an_s1;
            ca_s1 <= bus.CATHODES;
            ca_s2 <= ca_s1;
        end
    end

    assign legal = ($countones(~an_s2) == 1);
    assign same  = ({an_s2, ca_s2} == {ref_an, ref_ca});

    always_comb begin
        case (an_s2)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    seg_decode u_dec (
        .seg   (ca_s2[6:0]),
        .hit   (d_hit),
        .blank (d_blank),
        .nib   (d_nib)
    );

    // ld = new reference pair; with a one-cycle window it captures at once.
    always_comb begin
        state_n = state;
        cnt_n   = stab_cnt;
        ld      = 1'b0;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                if (legal) ld = 1'b1;
            end
            SETTLE: begin
                if (!legal) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (same) begin
                    if (stab_cnt == S_MAX - 1'b1) begin
                        cap     = 1'b1;
                        cnt_n   = S_MAX;
                        state_n = HOLD;
                    end else begin
                        cnt_n = stab_cnt + 1'b1;
                    end
                end else begin
                    ld = 1'b1;
                end
            end
            HOLD: begin
                if (!same) begin
                    if (legal) begin
                        ld = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (ld) begin
            cnt_n = SW'(1);
            if (S_MAX == SW'(1)) begin
                cap     = 1'b1;
                state_n = HOLD;
            end else begin
                state_n = SETTLE;
            end
        end
    end

    assign to_n      = legal ? '0 : ((to_cnt == T_MAX) ? to_cnt : to_cnt + 1'b1);
    assign to_hit    = !legal && (to_n == T_MAX);
    assign seen_full = (seen == 4'hF);
    assign cap_mask  = cap ? (4'b0001 << idx) : 4'b0000;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            stab_cnt <= '0;
            ref_an   <= 4'hF;
            ref_ca   <= 8'hFF;
        end else begin
            state    <= state_n;
            stab_cnt <= cnt_n;
            if (ld) begin
                ref_an <= an_s2;
                ref_ca <= ca_s2;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            digits <= '0;
            dp     <= '0;
            blank  <= '0;
            err    <= '0;
        end else if (cap) begin
            dp[idx] <= ~ca_s2[7];
            if (d_hit) begin
                digits[4*idx +: 4] <= d_nib;
                blank[idx]         <= 1'b0;
            end else if (d_blank) begin
                blank[idx] <= 1'b1;
            end else begin
                err[idx] <= 1'b1;
            end
        end
    end

    // A capture in the strobe cycle lands after the clear of seen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt    <= '0;
            seen      <= '0;
            frame_stb <= 1'b0;
            valid     <= 1'b0;
            disp_off  <= 1'b0;
        end else begin
            to_cnt    <= to_n;
            disp_off  <= to_hit;
            frame_stb <= seen_full && !to_hit;
            if (to_hit) begin
                seen  <= '0;
                valid <= 1'b0;
            end else begin
                seen <= (seen_full ? 4'b0000 : seen) | cap_mask;
                if (seen_full) valid <= 1'b1;
            end
        end
    end

    assign bus.DIGITS    = digits;
    assign bus.DP        = dp;
    assign bus.BLANK     = blank;
    assign bus.ERR       = err;
    assign bus.FRAME_STB = frame_stb;
    assign bus.VALID     = valid;
    assign bus.DISP_OFF  = disp_off;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture with a frame scoreboard.
// Expected frames are queued when the completing digit is driven.
module tb_sevseg_capture;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    sevseg_capture_if bus ();

    sevseg_capture #(
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [3:0]  er;
    } frame_t;

    frame_t q[$];

    logic [6:0] hex_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks   = 0;
    int failures = 0;
    int nstb     = 0;

    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_bl, m_er, m_seen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic int an_idx(input logic [3:0] an);
        int k = 0;
        for (int i = 0; i < 4; i++)
            if (!an[i]) k = i;
        return k;
    endfunction

    task automatic model_reset();
        m_dig  = '0;
        m_dp   = '0;
        m_bl   = '0;
        m_er   = '0;
        m_seen = '0;
    endtask

    task automatic model_cap(input logic [3:0] an, input logic [7:0] ca);
        int  k;
        bit  hit;
        frame_t f;
        k   = an_idx(an);
        hit = 1'b0;
        m_dp[k] = ~ca[7];
        for (int i = 0; i < 16; i++) begin
            if (ca[6:0] == hex_tbl[i]) begin
                hit = 1'b1;
                m_dig[4*k +: 4] = 4'(i);
                m_bl[k] = 1'b0;
            end
        end
        if (!hit) begin
            if (ca[6:0] == 7'h7F) m_bl[k] = 1'b1;
            else                  m_er[k] = 1'b1;
        end
        m_seen[k] = 1'b1;
        if (m_seen == 4'hF) begin
            f.d  = m_dig;
            f.dp = m_dp;
            f.bl = m_bl;
            f.er = m_er;
            q.push_back(f);
            m_seen = '0;
        end
    endtask

    // Hold one (anode, cathode) pair for n cycles and update the model.
    task automatic step(input logic [3:0] an, input logic [7:0] ca,
                        input int n);
        @(negedge CLK);
        bus.ANODES   = an;
        bus.CATHODES = ca;
        if (is_legal(an) && n >= 18) model_cap(an, ca);
        if (!is_legal(an) && n >= 66) m_seen = '0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every strobe must match the oldest queued frame.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus.FRAME_STB === 1'b1) begin
            nstb++;
            if (q.size() == 0) begin
                chk("frame_unexpected", 32'(bus.FRAME_STB), 32'd0);
            end else begin
                frame_t f;
                f = q.pop_front();
                chk("frame_digits", 32'(bus.DIGITS), 32'(f.d));
                chk("frame_dp",     32'(bus.DP),     32'(f.dp));
                chk("frame_blank",  32'(bus.BLANK),  32'(f.bl));
                chk("frame_err",    32'(bus.ERR),    32'(f.er));
                chk("frame_valid",  32'(bus.VALID),  32'd1);
            end
        end
    end

    initial begin
        model_reset();
        RST_N        = 1'b0;
        bus.ANODES   = 4'hF;
        bus.CATHODES = 8'hFF;
        #12;
        chk("rst_digits", 32'(bus.DIGITS),    32'h0);
        chk("rst_flags",  32'({bus.DP, bus.BLANK, bus.ERR}), 32'h0);
        chk("rst_stb",    32'(bus.FRAME_STB), 32'd0);
        chk("rst_valid",  32'(bus.VALID),     32'd0);
        chk("rst_off",    32'(bus.DISP_OFF),  32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Two full scans of 1,2,3,4.
        for (int s = 0; s < 2; s++) begin
            step(4'b0111, 8'hF9, 40);
            step(4'b1011, 8'hA4, 40);
            step(4'b1101, 8'hB0, 40);
            step(4'b1110, 8'h99, 40);
            chk("scan_digits", 32'(bus.DIGITS), 32'h1234);
            chk("scan_dp",     32'(bus.DP),     32'h0);
            chk("scan_valid",  32'(bus.VALID),  32'd1);
        end
        chk("scan_frames", 32'(nstb), 32'd2);

        // Short glitch on digit 0, then the real value.
        step(4'b1110, 8'hC0, 10);
        chk("glitch_hold", 32'(bus.DIGITS[3:0]), 32'h4);
        @(negedge CLK);
        bus.CATHODES = 8'h80;
        repeat (17) @(posedge CLK);
        #1;
        chk("glitch_pre", 32'(bus.DIGITS[3:0]), 32'h4);
        @(posedge CLK);
        #1;
        chk("glitch_cap", 32'(bus.DIGITS[3:0]), 32'h8);
        model_cap(4'b1110, 8'h80);
        repeat (12) @(posedge CLK);
        #1;

        // Blank on digit 2, illegal pattern on digit 1.
        step(4'b1011, 8'hFF, 40);
        step(4'b1101, 8'hAA, 40);
        step(4'b0111, 8'hF9, 40);
        chk("bl_blank",  32'(bus.BLANK),  32'b0100);
        chk("bl_err",    32'(bus.ERR),    32'b0010);
        chk("bl_digits", 32'(bus.DIGITS), 32'h1238);
        step(4'b1101, 8'hB0, 40);
        chk("err_sticky", 32'(bus.ERR),   32'b0010);
        chk("bl_keep",    32'(bus.BLANK), 32'b0100);

        // Illegal anodes mixed with a single legal digit.
        step(4'b1110, 8'hF9, 40);
        chk("one_digit", 32'(bus.DIGITS), 32'h1231);
        step(4'b0101, 8'h82, 40);
        chk("illegal_nocap", 32'(bus.DIGITS), 32'h1231);
        step(4'b1110, 8'h82, 40);
        chk("legal_cap", 32'(bus.DIGITS), 32'h1236);

        // Timeout.
        step(4'b1111, 8'hFF, 70);
        chk("to_off",    32'(bus.DISP_OFF), 32'd1);
        chk("to_valid",  32'(bus.VALID),    32'd0);
        chk("to_digits", 32'(bus.DIGITS),   32'h1236);
        step(4'b1110, 8'h99, 4);
        chk("to_clear", 32'(bus.DISP_OFF), 32'd0);

        // Asynchronous reset in the middle of a scan.
        step(4'b0111, 8'hF9, 40);
        step(4'b1011, 8'hA4, 40);
        step(4'b1101, 8'hB0, 10);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst_digits", 32'(bus.DIGITS), 32'h0);
        chk("arst_flags",  32'({bus.DP, bus.BLANK, bus.ERR}), 32'h0);
        chk("arst_out",    32'({bus.FRAME_STB, bus.VALID, bus.DISP_OFF}), 32'h0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Fresh frame, digit 3 shows 0 with DP lit.
        step(4'b0111, 8'h40, 40);
        step(4'b1011, 8'hA4, 40);
        step(4'b1101, 8'hB0, 40);
        chk("post_rst_valid",  32'(bus.VALID), 32'd0);
        chk("post_rst_frames", 32'(nstb),      32'd3);
        step(4'b1110, 8'h99, 40);
        chk("dp_digits", 32'(bus.DIGITS), 32'h0234);
        chk("dp_dp",     32'(bus.DP),     32'b1000);
        chk("dp_valid",  32'(bus.VALID),  32'd1);

        repeat (4) @(posedge CLK);
        #1;
        chk("frames_total", 32'(nstb),     32'd4);
        chk("queue_empty",  32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevseg_capture.md
Name: sevseg_capture

Overview:
Reader side of the four-digit multiplexed seven-segment interface driven by RAT_WRAPPER's display scanner.
- Samples ANODES/CATHODES each clock.
- Waits for each digit's drive to settle, then decodes the cathode pattern back to a hex nibble and DP bit.
- Reports a coherent 4-digit frame.
- Used in system benches and in hardware loopback to check displayed values without eyeballing the board.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples of one (anode, cathode) pair required before capture; legal range 1..65535.
TIMEOUT_CYCLES, 65536, cycles with no legal anode before DISP_OFF asserts; legal range 2..2^24.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST_N  input  1  asynchronous active-low reset.
ANODES  input  4  digit selects, active-low; legal when exactly one bit is 0.
CATHODES  input  8  segments, active-low; bit order {DP,G,F,E,D,C,B,A}.
DIGITS  output  16  captured nibbles; digit k is in [4k+3:4k]; digit 0 is ANODES[0].
DP  output  4  captured decimal points, 1 = lit.
BLANK  output  4  1 = digit captured with all of G..A off.
ERR  output  4  sticky per digit; 1 = a non-table, non-blank pattern was captured.
FRAME_STB  output  1  one-cycle pulse when all four digits have been captured since the last pulse or since reset.
VALID  output  1  set with the first FRAME_STB; cleared only by reset or DISP_OFF.
DISP_OFF  output  1  no legal anode for TIMEOUT_CYCLES.

Behaviour:
Reset (RST_N=0, asynchronous):
- DIGITS, DP, BLANK and ERR are all 0.
- FRAME_STB, VALID and DISP_OFF are 0.
- FSM is in IDLE and all counters are 0.

Input sampling:
- ANODES and CATHODES each pass through a two-flop synchronizer.
- All logic below uses the synchronized values.
- Input-to-capture latency is 2 + STABLE_CYCLES cycles.

Legal anode:
- Exactly one zero in ANODES.
- Anything else (all ones, or several zeros) is "no digit".

FSM states and transitions:
- IDLE: wait for a legal anode. On a legal anode, latch the sample as the reference pair, set stab_cnt=1, go to SETTLE.
- SETTLE:
  - Sample equals the reference: increment stab_cnt.
  - stab_cnt reaches STABLE_CYCLES: capture and go to HOLD.
  - Sample differs but the anode is legal: reload the reference, set stab_cnt=1, stay in SETTLE.
  - Illegal anode: go to IDLE.
- HOLD: digit already captured. Stay while the sample is unchanged (no repeated capture). On any change, go to IDLE if the anode is illegal, otherwise to SETTLE with a new reference.
- STABLE_CYCLES=1: capture happens on the cycle the reference is latched, and the FSM enters HOLD directly.

Capture of digit k:
- Look up CATHODES[6:0] in the package table.
- Hit: DIGITS[k] = table index, BLANK[k]=0.
- Pattern 7'h7F (all segments off): BLANK[k]=1, DIGITS[k] unchanged.
- Miss: ERR[k]=1, DIGITS[k] unchanged.
- DP[k] = ~CATHODES[7] in every case.
- seen[k] is set.

Frame tracking:
- When seen becomes 4'b1111, FRAME_STB pulses on the following cycle, VALID is set, and seen clears in that same cycle.
- A capture landing in that same cycle sets its seen bit after the clear; the capture is not lost.
- A re-capture of a digit already in seen updates that digit's data and does not change seen.

Timeout:
- to_cnt increments every cycle with no legal anode and saturates at TIMEOUT_CYCLES.
- Reaching TIMEOUT_CYCLES sets DISP_OFF, clears VALID and seen, and keeps DIGITS.
- Any legal anode zeroes to_cnt and clears DISP_OFF.

Counter widths:
- stab_cnt: $clog2(STABLE_CYCLES+1) bits, saturating.
- to_cnt: $clog2(TIMEOUT_CYCLES+1) bits, saturating.
- No wrap-around is permitted on either counter.

Reset mid-frame: everything returns to the reset values immediately; partial frames are discarded.

Decomposition:
- sevseg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - Constant array SEG_HEX[16] with patterns {G..A}, active-low, 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - typedef cap_state_t {IDLE, SETTLE, HOLD}.
- The display driver imports the same table so encoder and decoder cannot diverge.
- Sub-module seg_decode: purely combinational, 7-bit pattern -> {hit, blank, nibble}. Everything else stays in sevseg_capture.

Test Plan:
1. Scan digits 3..0 with patterns for 1,2,3,4 (F9,A4,B0,99), 40 cycles per digit, STABLE_CYCLES=16 -> DIGITS=16'h1234, DP=0, FRAME_STB pulses once per full scan, VALID=1 after the first scan.
2. Glitch: digit 0 shows C0 for 10 cycles, then 80 for 30 cycles -> DIGITS[3:0]=8, never 0; capture occurs 2+16 cycles after 80 is applied.
3. Pattern 7F on digit 2 and 0xAA (pattern 2A, not in the table) on digit 1 -> BLANK=4'b0100, ERR=4'b0010, both digits keep their old nibbles, ERR stays set until reset.
4. Illegal ANODES=4'b0101 mixed with a single digit held for the full scan period -> no capture is made during the illegal-anode periods; with TIMEOUT_CYCLES=64 and ANODES=4'hF for 70 cycles -> DISP_OFF=1, VALID=0, DIGITS retained; one legal anode then clears DISP_OFF.
5. RST_N low mid-scan, asynchronously between clock edges -> all outputs are 0 before the next edge; the first FRAME_STB after release needs four fresh captures.
6. Cathode 8'h40 on digit 3 (DP lit, pattern 0) -> DP[3]=1, DIGITS[15:12]=0.
